// File: rtl/mux_frame_serializer.sv
// Latches a 2**K-bit frame onto an external 2**K:1 mux and walks its select to stream the
// frame out one bit per valid/ready beat. Define MUX_SERIALIZER_PARITY_EN for a trailing even-parity beat.
module mux_frame_serializer #(
    parameter int K = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2**K-1:0] in_data,
    input  logic            msb_first,
    output logic [2**K-1:0] mux_in,
    output logic [K-1:0]    mux_sel,
    input  logic            mux_y,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_bit,
    output logic            out_first,
    output logic            out_last,
    output logic            busy
);
    localparam int             N         = 2**K;
    localparam logic [K:0]     LAST_BEAT = (K+1)'(N - 1);
    localparam logic [K:0]     BEAT_ONE  = (K+1)'(1);
    localparam logic [K-1:0]   SEL_ONE   = K'(1);

`ifdef MUX_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SEND, PARITY} state_t;
`else
    typedef enum logic {IDLE, SEND} state_t;
`endif

    state_t       state_q, state_d;
    logic [N-1:0] mux_in_q, mux_in_d;
    logic [K-1:0] mux_sel_q, mux_sel_d;
    logic [K:0]   beat_q, beat_d;
    logic         dir_q, dir_d;
    logic         last_beat;
`ifdef MUX_SERIALIZER_PARITY_EN
    logic         par_q, par_d;
`endif

    assign last_beat = (beat_q == LAST_BEAT);
    assign mux_in    = mux_in_q;
    assign mux_sel   = mux_sel_q;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d   = state_q;
        mux_in_d  = mux_in_q;
        mux_sel_d = mux_sel_q;
        beat_d    = beat_q;
        dir_d     = dir_q;
`ifdef MUX_SERIALIZER_PARITY_EN
        par_d     = par_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        out_first = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d   = SEND;
                    mux_in_d  = in_data;
                    dir_d     = msb_first;
                    mux_sel_d = msb_first ? '1 : '0;
                    beat_d    = '0;
`ifdef MUX_SERIALIZER_PARITY_EN
                    par_d     = ^in_data;
`endif
                end
            end
            SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_bit   = mux_y;
                out_first = (beat_q == '0);
`ifndef MUX_SERIALIZER_PARITY_EN
                out_last  = last_beat;
`endif
                if (out_ready) begin
                    if (last_beat) begin
                        // Select is left on the final channel; it is only reloaded at acceptance.
`ifdef MUX_SERIALIZER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        beat_d    = beat_q + BEAT_ONE;
                        mux_sel_d = dir_q ? mux_sel_q - SEL_ONE : mux_sel_q + SEL_ONE;
                    end
                end
            end
`ifdef MUX_SERIALIZER_PARITY_EN
            PARITY: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_bit   = par_q;
                out_last  = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the frame register is reset too, so mux_in reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mux_in_q  <= '0;
            mux_sel_q <= '0;
            beat_q    <= '0;
            dir_q     <= 1'b0;
`ifdef MUX_SERIALIZER_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking updates so every flop samples the same pre-edge values.
            state_q   <= state_d;
            mux_in_q  <= mux_in_d;
            mux_sel_q <= mux_sel_d;
            beat_q    <= beat_d;
            dir_q     <= dir_d;
`ifdef MUX_SERIALIZER_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

endmodule
